// File: rtl/return_stack_if.sv
// Return-address stack bus: Decode/Fetch side (master) and the stack (slave).
// Signals:
//   push, pop, pushPC, clrErr         - commands and return address from Decode
//   PCstack                           - current top of stack (0 when empty)
//   empty, full, count                - occupancy status
//   overflow, underflow               - sticky error flags
interface return_stack_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 3
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] pushPC;
    logic             clrErr;
    logic [WIDTH-1:0] PCstack;
    logic             empty;
    logic             full;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, pushPC, clrErr,
        input  PCstack, empty, full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, pushPC, clrErr,
        output PCstack, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/return_stack.sv
// Hardware return-address stack beside Fetch; provides the PCstack redirect.
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high; discards all entries
//   bus    - return_stack_if.slave (push/pop/pushPC/clrErr in;
//            PCstack/empty/full/count/overflow/underflow out)
// Build option:
//   RSTACK_WRAP_EN - when defined, a push on a full stack overwrites the
//                    oldest entry; otherwise that push is dropped.
module return_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    return_stack_if.slave  bus
);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic             ovf_set;
    logic             udf_set;
    logic             is_empty;
    logic             is_full;
    logic [AW-1:0]    top_idx;

    assign is_empty = (count_q == CW'(0));
    assign is_full  = (count_q == CW'(DEPTH));
    assign top_idx  = wp_q - AW'(1);

    // Command decode: next pointer/count, memory write and error events.
    always_comb begin
        wp_d    = wp_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = wp_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;

        case ({bus.push, bus.pop})
            2'b11: begin
                if (is_empty) begin
                    // Nothing to replace: behaves as a push, but the pop still errs.
                    wr_en   = 1'b1;
                    wp_d    = wp_q + AW'(1);
                    count_d = CW'(1);
                    udf_set = 1'b1;
                end else begin
                    // Tail call: overwrite the top in place.
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end
            end
            2'b10: begin
                if (!is_full) begin
                    wr_en   = 1'b1;
                    wp_d    = wp_q + AW'(1);
                    count_d = count_q + CW'(1);
                end else begin
                    ovf_set = 1'b1;
`ifdef RSTACK_WRAP_EN
                    // Circular: oldest entry sits at wp when full.
                    wr_en   = 1'b1;
                    wp_d    = wp_q + AW'(1);
`endif
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    wp_d    = top_idx;
                    count_d = count_q - CW'(1);
                end else begin
                    udf_set = 1'b1;
                end
            end
            default: ;
        endcase

        // A new error in the clearing cycle survives the clear.
        overflow_d  = (overflow_q  & ~bus.clrErr) | ovf_set;
        underflow_d = (underflow_q & ~bus.clrErr) | udf_set;
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage; not reset since it is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wr_idx] <= bus.pushPC;
        end
    end

    assign bus.PCstack   = is_empty ? '0 : mem_q[top_idx];
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: doc/return_stack.md
# return_stack

Hardware return-address stack for the RISC core. It sits beside Fetch and produces the `PCstack` redirect target. Decode pushes the return address on a call and pops it on a return. Fetch consumes `PCstack` in the same cycle in which its `PCsrc` selects the stack source and `pop` is asserted.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; must be a power of two, minimum 2.
- `AW`, 3: log2(`DEPTH`); pointer width.
- `WIDTH`, 32: address width; matches the Fetch PC width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `push`  in  1  call: store `pushPC` as the new top.
- `pop`  in  1  return: discard the top; Fetch takes the current `PCstack` this cycle.
- `pushPC`  in  `WIDTH`  return address, precomputed by Decode (call PC + 1).
- `clrErr`  in  1  clears the sticky error flags.
- `PCstack`  out  `WIDTH`  current top-of-stack address; 0 when empty.
- `empty`  out  1  count == 0.
- `full`  out  1  count == `DEPTH`.
- `count`  out  `AW+1`  number of valid entries, 0..`DEPTH`.
- `overflow`  out  1  sticky: a push was made while the stack was full.
- `underflow`  out  1  sticky: a pop was made while the stack was empty.

## Operation
- Storage is `DEPTH` x `WIDTH` registers (`mem`), a write pointer `wp` (`AW` bits, wraps modulo `DEPTH`) and `count`.
- Top index is `wp - 1` modulo `DEPTH`. `PCstack = empty ? 0 : mem[wp-1]`. It is combinational from registered state only; there is no combinational path from `push`, `pop` or `pushPC`.
- Commands, evaluated at the clock edge when `reset` = 0:
  - Idle (`push`=0, `pop`=0): no change.
  - Push, not full: `mem[wp] <= pushPC`, `wp++`, `count++`.
  - Push, full: see Configuration. `overflow` is set in both builds.
  - Pop, not empty: `wp--`, `count--`. Memory is unchanged.
  - Pop, empty: no pointer or count change; `underflow` is set; `PCstack` stays 0.
  - Push+pop, not empty: replace the top. `mem[wp-1] <= pushPC`; `wp` and `count` are unchanged. This is tail-call behaviour.
  - Push+pop, empty: `mem[wp] <= pushPC`, `wp++`, `count` becomes 1, and `underflow` is set.
- Sticky flags:
  - `clrErr` clears `overflow` and `underflow` at the next edge.
  - If a new error occurs in the same cycle as `clrErr`, the new error is kept (set wins).
- Arithmetic:
  - `wp` wraps naturally in `AW` bits.
  - `count` is saturating and never exceeds `DEPTH` or goes below 0.

## Timing
- Reset values: `wp`=0, `count`=0, `overflow`=0, `underflow`=0. Hence `PCstack`=0, `empty`=1, `full`=0. `mem` is not reset and is never visible while empty.
- `reset` takes priority over all commands. A reset in mid-operation discards every entry in one cycle.
- Push latency is 1: the pushed value appears on `PCstack` in the cycle after the push edge.
- Pop: `PCstack` holds the popped address during the pop cycle. The next entry down is visible in the following cycle.
- Back-to-back push/pop on consecutive cycles is supported with no bubbles.
- Flags, `count`, `empty` and `full` update at the same edge as the pointer.

## Configuration
- `RSTACK_WRAP_EN`
  - Defined: push on a full stack overwrites the oldest entry (circular behaviour). `mem[wp] <= pushPC`, `wp++`, `count` stays at `DEPTH`, and `overflow` is set. This allows deep recursion while keeping the most recent `DEPTH` return addresses.
  - Undefined (default): push on a full stack is dropped. `mem`, `wp` and `count` are unchanged, `PCstack` keeps the old top, and `overflow` is set.

## Test plan
- Reset then idle: `reset`=1 for 1 cycle → `PCstack`=0, `empty`=1, `count`=0, both flags 0.
- Three pushes, 0x10, 0x20, 0x30, then three pops → `PCstack` shows 0x30, 0x20, 0x10 during the pop cycles. `empty`=1 afterwards and `underflow`=0.
- Push+pop at count 2, top 0x20, `pushPC`=0x44 → `count` stays 2 and `PCstack`=0x44 the next cycle. Then push+pop when empty → `count`=1 and `underflow`=1.
- Fill 8 pushes (0x1..0x8), then push 0x9:
  - Without the macro: `full`=1, `overflow`=1. Eight pops yield 0x8..0x1.
  - With `RSTACK_WRAP_EN`: eight pops yield 0x9..0x2.
- Pop when empty, with `clrErr` asserted in the same cycle → `underflow` stays 1. A lone `clrErr` next cycle → `underflow`=0.
- Reset mid-operation: at `count`=5, assert `reset` together with `push` → `count`=0 and `PCstack`=0 next cycle, and the push is ignored.
